// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin grant arbiter.
//   arb_state_t : FSM encoding (IDLE, GRANT, GAP)
//   idw()       : index width helper, never returns 0 so N=1 style corners stay legal
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } arb_state_t;

  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant_fsm_if.sv
// Requester-side bundle of the round-robin arbiter.
//   req      : level request per requester (driven by master)
//   grant    : registered one-hot grant
//   grant_id : index of current owner, valid while busy
//   busy     : arbiter is in GRANT
//   preempt  : one-cycle pulse when the owner was force-released by timeout
interface rr_grant_fsm_if
  import arb_pkg::*;
#(
  parameter int unsigned N = 4
);

  localparam int unsigned IdW = idw(N);

  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic [IdW-1:0] grant_id;
  logic           busy;
  logic           preempt;

  modport master (
    output req,
    input  grant,
    input  grant_id,
    input  busy,
    input  preempt
  );

  modport slave (
    input  req,
    output grant,
    output grant_id,
    output busy,
    output preempt
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
//   req     : request vector
//   last_id : index of the previous winner; scanning starts at last_id+1
//   any     : at least one request set
//   win_id  : first set request found in rotated order
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  localparam int unsigned IdW = idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] last_id,
  output logic           any,
  output logic [IdW-1:0] win_id
);

  logic [31:0] idx;

  always_comb begin
    any    = 1'b0;
    win_id = '0;
    idx    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // last_id <= N-1, so one conditional subtract keeps idx inside 0..N-1.
      idx = 32'(last_id) + 32'd1 + i;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx[IdW-1:0]]) begin
        any    = 1'b1;
        win_id = idx[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_grant_fsm.sv
// Round-robin arbiter for one single-owner resource shared by N requesters.
// The owner keeps the grant while its req stays high; if others are waiting it is
// force-released after MAX_HOLD grant cycles. Every ownership change passes through
// a one-cycle GAP followed by IDLE, where the next winner is picked.
//   clk     : rising-edge clock
//   areset  : asynchronous active-high reset
//   arb     : requester bundle (req in; grant, grant_id, busy, preempt out)
module rr_grant_fsm
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           areset,
  rr_grant_fsm_if.slave  arb
);

  localparam int unsigned IdW   = idw(N);
  localparam int unsigned HoldW = idw(MAX_HOLD);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IdW-1:0]   grant_id_q, grant_id_d;
  logic [IdW-1:0]   last_id_q, last_id_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             busy_q, busy_d;
  logic             preempt_q, preempt_d;

  logic           pick_any;
  logic [IdW-1:0] pick_id;
  logic           owner_req;
  logic           contended;
  logic           timeout;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req     (arb.req),
    .last_id (last_id_q),
    .any     (pick_any),
    .win_id  (pick_id)
  );

  assign owner_req = arb.req[grant_id_q];
  assign contended = |(arb.req & ~grant_q);
  assign timeout   = (hold_cnt_q == HoldMax) && contended;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d          = GRANT;
          grant_d          = '0;
          grant_d[pick_id] = 1'b1;
          grant_id_d       = pick_id;
          last_id_d        = pick_id;
          hold_cnt_d       = '0;
        end
      end
      GRANT: begin
        if (hold_cnt_q != HoldMax) hold_cnt_d = hold_cnt_q + HoldW'(1);
        // Release has priority over timeout: a voluntary drop is never a preempt.
        if (!owner_req) begin
          state_d = GAP;
          grant_d = '0;
        end else if (timeout) begin
          state_d   = GAP;
          grant_d   = '0;
          preempt_d = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d == GRANT);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_id_q  <= IdW'(N - 1);
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      hold_cnt_q <= hold_cnt_d;
      busy_q     <= busy_d;
      preempt_q  <= preempt_d;
    end
  end

  assign arb.grant    = grant_q;
  assign arb.grant_id = grant_id_q;
  assign arb.busy     = busy_q;
  assign arb.preempt  = preempt_q;

  a_grant_onehot: assert property (@(posedge clk) disable iff (areset)
    $onehot0(grant_q));
  a_busy_matches: assert property (@(posedge clk) disable iff (areset)
    busy_q == (grant_q != '0));
  a_preempt_gap: assert property (@(posedge clk) disable iff (areset)
    preempt_q |-> (state_q == GAP));

endmodule

// File: tb/tb_rr_grant_fsm.sv
// Directed self-checking bench for rr_grant_fsm (N=4, MAX_HOLD=8).
module tb_rr_grant_fsm;

  logic clk;
  logic areset;
  int   n_checks;
  int   n_errors;

  rr_grant_fsm_if #(.N(4)) arb_if ();

  rr_grant_fsm #(
    .N        (4),
    .MAX_HOLD (8)
  ) dut (
    .clk    (clk),
    .areset (areset),
    .arb    (arb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic b,
                            input logic p, input int id);
    check({tag, "/grant"}, 32'(arb_if.grant), 32'(g));
    check({tag, "/busy"}, 32'(arb_if.busy), 32'(b));
    check({tag, "/preempt"}, 32'(arb_if.preempt), 32'(p));
    if (b) check({tag, "/id"}, 32'(arb_if.grant_id), 32'(id));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; completes well before the next one.
  task automatic do_reset();
    areset = 1'b1;
    #2;
    expect_out("in_reset", 4'b0000, 1'b0, 1'b0, 0);
    areset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    areset     = 1'b1;
    arb_if.req = 4'b1111;

    // 1 Reset held across an edge, then first grant goes to requester 0.
    #2;
    expect_out("rst0", 4'b0000, 1'b0, 1'b0, 0);
    step();
    expect_out("rst1", 4'b0000, 1'b0, 1'b0, 0);
    areset = 1'b0;
    step();
    expect_out("first", 4'b0001, 1'b1, 1'b0, 0);
    arb_if.req = 4'b0000;
    step();
    expect_out("first_gap", 4'b0000, 1'b0, 1'b0, 0);
    step();

    // 2 Single owner for 3 cycles, one GAP, then IDLE.
    arb_if.req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_out("single", 4'b0100, 1'b1, 1'b0, 2);
    end
    arb_if.req = 4'b0000;
    step();
    expect_out("single_gap", 4'b0000, 1'b0, 1'b0, 0);
    step();
    expect_out("single_idle", 4'b0000, 1'b0, 1'b0, 0);

    // 3 Rotation 1,3,1,3 from reset.
    do_reset();
    arb_if.req = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      automatic int o = (n % 2 == 0) ? 1 : 3;
      automatic logic [3:0] g = 4'b0001 << o;
      step();
      expect_out("rot_a", g, 1'b1, 1'b0, o);
      step();
      expect_out("rot_b", g, 1'b1, 1'b0, o);
      arb_if.req = 4'b1010 & ~g;
      step();
      expect_out("rot_gap", 4'b0000, 1'b0, 1'b0, 0);
      arb_if.req = 4'b1010;
      step();
      expect_out("rot_idle", 4'b0000, 1'b0, 1'b0, 0);
    end

    // 4 Timeout with 0 and 2 contending, fairness back to 0, then uncontended hold.
    arb_if.req = 4'b0101;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      expect_out("to_own0", 4'b0001, 1'b1, 1'b0, 0);
    end
    step();
    expect_out("to_pre0", 4'b0000, 1'b0, 1'b1, 0);
    step();
    expect_out("to_idle0", 4'b0000, 1'b0, 1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      expect_out("to_own2", 4'b0100, 1'b1, 1'b0, 2);
    end
    step();
    expect_out("to_pre2", 4'b0000, 1'b0, 1'b1, 0);
    step();
    expect_out("to_idle2", 4'b0000, 1'b0, 1'b0, 0);
    step();
    expect_out("to_back0", 4'b0001, 1'b1, 1'b0, 0);
    arb_if.req = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      step();
      expect_out("uncont", 4'b0001, 1'b1, 1'b0, 0);
    end

    // 5 Wrap-around from last_id=3, then release coinciding with timeout.
    arb_if.req = 4'b0000;
    step();
    expect_out("w_gap0", 4'b0000, 1'b0, 1'b0, 0);
    step();
    arb_if.req = 4'b1000;
    step();
    expect_out("w_own3", 4'b1000, 1'b1, 1'b0, 3);
    arb_if.req = 4'b0000;
    step();
    step();
    arb_if.req = 4'b0101;
    step();
    expect_out("wrap", 4'b0001, 1'b1, 1'b0, 0);
    for (int k = 0; k < 7; k++) begin
      step();
      expect_out("sim_hold", 4'b0001, 1'b1, 1'b0, 0);
    end
    arb_if.req = 4'b0100;
    step();
    expect_out("sim_rel", 4'b0000, 1'b0, 1'b0, 0);
    step();
    expect_out("sim_idle", 4'b0000, 1'b0, 1'b0, 0);
    step();
    expect_out("sim_own2", 4'b0100, 1'b1, 1'b0, 2);

    // 6 Asynchronous reset mid-GRANT while requester 0 owns (last_id=0).
    arb_if.req = 4'b0000;
    step();
    step();
    arb_if.req = 4'b0001;
    step();
    expect_out("mid_own0", 4'b0001, 1'b1, 1'b0, 0);
    #3;
    areset = 1'b1;
    #1;
    expect_out("mid_async", 4'b0000, 1'b0, 1'b0, 0);
    arb_if.req = 4'b0011;
    #1;
    areset = 1'b0;
    step();
    expect_out("mid_after", 4'b0001, 1'b1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
